// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS serial writer: frame layout, channel IDs
// and the transfer FSM encoding.
package dds_pkg;

    localparam int DDS_WORD_W  = 11;
    localparam int DDS_FRAME_W = 16;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FRAME_A = 3'd1,
        ST_GAP     = 3'd2,
        ST_FRAME_B = 3'd3,
        ST_UPDATE  = 3'd4
    } dds_state_t;

    // bit15 = 0, bit14 = channel, zero padding, then the control word in the low bits
    function automatic logic [DDS_FRAME_W-1:0] make_frame(input logic ch,
                                                          input logic [DDS_WORD_W-1:0] word);
        return {1'b0, ch, {(DDS_FRAME_W-2-DDS_WORD_W){1'b0}}, word};
    endfunction

endpackage

// File: rtl/dds_bit_timer.sv
// Serial bit timing: CLK_DIV prescaler, sclk toggle, rise/fall ticks and a frame bit
// counter. Everything is held at zero while run is low, so each frame starts aligned.
module dds_bit_timer #(
    parameter int CLK_DIV = 2,
    parameter int FRAME_W = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick,
    output logic frame_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_W);

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             sclk_q;
    logic             half_end;

    // Ticks are asserted in the last cycle of a half-period, so the edge lands on the next clock
    assign half_end   = run && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise_tick  = half_end && !sclk_q;
    assign fall_tick  = half_end && sclk_q;
    assign frame_done = fall_tick && (bit_cnt == BIT_W'(FRAME_W - 1));
    assign sclk       = sclk_q;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk_q  <= 1'b0;
        end else begin
            if (half_end) begin
                div_cnt <= '0;
                sclk_q  <= !sclk_q;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fall_tick)
                bit_cnt <= frame_done ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dds_serial_writer.sv
// Shifts channel A then channel B control words to the DDS over a 3-wire bus, then
// pulses io_update. Holds one pending request; overwriting it sets a sticky overrun.
module dds_serial_writer
    import dds_pkg::*;
#(
    parameter int WORD_W   = DDS_WORD_W,
    parameter int FRAME_W  = DDS_FRAME_W,
    parameter int CLK_DIV  = 2,
    parameter int UPDATE_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] word_a,
    input  logic [WORD_W-1:0] word_b,
    input  logic              word_valid,
    input  logic              overrun_clr,
    output logic              sclk,
    output logic              sdata,
    output logic              cs_n,
    output logic              io_update,
    output logic              busy,
    output logic              overrun,
    output logic [2:0]        state_dbg
);

    localparam int P        = 2 * CLK_DIV;
    localparam int WAIT_MAX = (P > UPDATE_W) ? P : UPDATE_W;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);

    dds_state_t        state, state_nx;
    logic [CNT_W-1:0]  wait_cnt;
    logic [FRAME_W-1:0] shreg;
    logic [WORD_W-1:0] word_b_q, pend_a, pend_b;
    logic              pend_valid;
    logic              load_a, load_b, take_pend, in_frame;
    logic              fall_tick, frame_done, rise_unused;

    assign in_frame = (state == ST_FRAME_A) || (state == ST_FRAME_B);

    dds_bit_timer #(.CLK_DIV(CLK_DIV), .FRAME_W(FRAME_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .run        (in_frame),
        .sclk       (sclk),
        .rise_tick  (rise_unused),
        .fall_tick  (fall_tick),
        .frame_done (frame_done)
    );

    // word_valid is a strobe with no back-pressure: every request is accepted, and one
    // that cannot be queued replaces the pending request and raises overrun.
    always_comb begin
        state_nx  = state;
        load_a    = 1'b0;
        load_b    = 1'b0;
        take_pend = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_valid) begin
                    state_nx  = ST_FRAME_A;
                    take_pend = 1'b1;
                end else if (word_valid) begin
                    state_nx = ST_FRAME_A;
                    load_a   = 1'b1;
                end
            end
            ST_FRAME_A: if (frame_done) state_nx = ST_GAP;
            ST_GAP: begin
                if (wait_cnt == CNT_W'(P - 1)) begin
                    state_nx = ST_FRAME_B;
                    load_b   = 1'b1;
                end
            end
            ST_FRAME_B: if (frame_done) state_nx = ST_UPDATE;
            ST_UPDATE: begin
                if (wait_cnt == CNT_W'(UPDATE_W - 1)) begin
                    if (pend_valid) begin
                        state_nx  = ST_FRAME_A;
                        take_pend = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            shreg      <= '0;
            word_b_q   <= '0;
            pend_a     <= '0;
            pend_b     <= '0;
            pend_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= (state_nx != state) ? '0 : wait_cnt + 1'b1;

            if (load_a) begin
                shreg    <= make_frame(CH_A, word_a);
                word_b_q <= word_b;
            end else if (take_pend) begin
                shreg    <= make_frame(CH_A, pend_a);
                word_b_q <= pend_b;
            end else if (load_b) begin
                shreg <= make_frame(CH_B, word_b_q);
            end else if (in_frame && fall_tick) begin
                shreg <= shreg << 1;
            end

            // A strobe coinciding with the pending slot being drained simply refills it
            if (word_valid && !load_a) begin
                pend_a     <= word_a;
                pend_b     <= word_b;
                pend_valid <= 1'b1;
            end else if (take_pend) begin
                pend_valid <= 1'b0;
            end

            if (word_valid && !load_a && pend_valid && !take_pend)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

    assign sdata     = in_frame ? shreg[FRAME_W-1] : 1'b0;
    assign cs_n      = !in_frame;
    assign io_update = (state == ST_UPDATE);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_dds_serial_writer.sv
// Directed bench for dds_serial_writer: default timing instance plus a CLK_DIV=1,
// UPDATE_W=1 instance; frames are captured on sclk rising edges.
module tb_dds_serial_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] word_a, word_b;
    logic        word_valid0, word_valid1, overrun_clr;

    logic sclk0, sdata0, cs_n0, io_update0, busy0, overrun0;
    logic sclk1, sdata1, cs_n1, io_update1, busy1, overrun1;
    logic [2:0] state_dbg0, state_dbg1;

    int errors = 0;
    int checks = 0;
    int rel;
    int act;
    logic        sel;
    logic        sclk_prev;
    logic [63:0] cap;
    logic m_sclk, m_sdata, m_cs_n, m_io_update, m_busy;

    always #5 clk = ~clk;

    dds_serial_writer dut0 (
        .clk(clk), .reset(reset), .word_a(word_a), .word_b(word_b),
        .word_valid(word_valid0), .overrun_clr(overrun_clr),
        .sclk(sclk0), .sdata(sdata0), .cs_n(cs_n0), .io_update(io_update0),
        .busy(busy0), .overrun(overrun0), .state_dbg(state_dbg0)
    );

    dds_serial_writer #(.CLK_DIV(1), .UPDATE_W(1)) dut1 (
        .clk(clk), .reset(reset), .word_a(word_a), .word_b(word_b),
        .word_valid(word_valid1), .overrun_clr(overrun_clr),
        .sclk(sclk1), .sdata(sdata1), .cs_n(cs_n1), .io_update(io_update1),
        .busy(busy1), .overrun(overrun1), .state_dbg(state_dbg1)
    );

    always_comb begin
        m_sclk      = sel ? sclk1 : sclk0;
        m_sdata     = sel ? sdata1 : sdata0;
        m_cs_n      = sel ? cs_n1 : cs_n0;
        m_io_update = sel ? io_update1 : io_update0;
        m_busy      = sel ? busy1 : busy0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; samples 1 time unit after the edge and captures sdata on sclk rises
    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
        if (m_sclk && !sclk_prev) cap = {cap[62:0], m_sdata};
        sclk_prev = m_sclk;
        if (!m_cs_n || m_io_update) act++;
    endtask

    task automatic wait_to(input int n);
        while (rel < n) tick();
    endtask

    task automatic start(input logic s, input logic [10:0] a, input logic [10:0] b);
        sel = s;
        word_a = a;
        word_b = b;
        if (s) word_valid1 = 1'b1; else word_valid0 = 1'b1;
        rel = 0;
        cap = '0;
        sclk_prev = 1'b0;
        tick();
        word_valid0 = 1'b0;
        word_valid1 = 1'b0;
    endtask

    task automatic strobe0(input logic [10:0] a, input logic [10:0] b, input logic clr);
        word_a = a;
        word_b = b;
        word_valid0 = 1'b1;
        overrun_clr = clr;
        tick();
        word_valid0 = 1'b0;
        overrun_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        word_a = '0;
        word_b = '0;
        word_valid0 = 1'b0;
        word_valid1 = 1'b0;
        overrun_clr = 1'b0;
        sel = 1'b0;
        rel = 0;
        act = 0;
        cap = '0;
        sclk_prev = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_sclk", sclk0, 0);
        check("rst_sdata", sdata0, 0);
        check("rst_cs_n", cs_n0, 1);
        check("rst_io_update", io_update0, 0);
        check("rst_busy", busy0, 0);
        check("rst_overrun", overrun0, 0);
        reset = 1'b0;
        repeat (2) tick();

        // Single request
        start(1'b0, 11'h5A3, 11'h123);
        check("t1_busy_T1", busy0, 1);
        check("t1_cs_n_T1", cs_n0, 0);
        check("t1_sdata_T1", sdata0, 0);
        check("t1_sclk_T1", sclk0, 0);
        wait_to(3);
        check("t1_sclk_rise_T3", sclk0, 1);
        wait_to(5);
        check("t1_sclk_fall_T5", sclk0, 0);
        wait_to(64);
        check("t1_cs_n_T64", cs_n0, 0);
        wait_to(65);
        check("t1_cs_n_gap_T65", cs_n0, 1);
        check("t1_frame_a", cap[15:0], 16'h05A3);
        wait_to(69);
        check("t1_cs_n_fb_T69", cs_n0, 0);
        wait_to(132);
        check("t1_io_update_T132", io_update0, 0);
        check("t1_frames", cap[31:0], {16'h05A3, 16'h4123});
        wait_to(133);
        check("t1_io_update_T133", io_update0, 1);
        wait_to(134);
        check("t1_io_update_T134", io_update0, 1);
        check("t1_busy_T134", busy0, 1);
        wait_to(135);
        check("t1_io_update_T135", io_update0, 0);
        check("t1_busy_T135", busy0, 0);
        repeat (3) tick();

        // Pending request taken with no idle gap
        start(1'b0, 11'h5A3, 11'h123);
        wait_to(20);
        strobe0(11'h7FF, 11'h000, 1'b0);
        wait_to(134);
        check("t2_io_update_T134", io_update0, 1);
        wait_to(135);
        check("t2_cs_n_T135", cs_n0, 0);
        check("t2_busy_T135", busy0, 1);
        wait_to(266);
        check("t2_frames", cap, {16'h05A3, 16'h4123, 16'h07FF, 16'h4000});
        wait_to(269);
        check("t2_busy_T269", busy0, 0);
        check("t2_overrun", overrun0, 0);
        repeat (3) tick();

        // Overwrite of a pending request
        start(1'b0, 11'h5A3, 11'h123);
        wait_to(20);
        strobe0(11'h111, 11'h222, 1'b0);
        check("t3_overrun_T21", overrun0, 0);
        wait_to(40);
        strobe0(11'h333, 11'h444, 1'b0);
        check("t3_overrun_T41", overrun0, 1);
        wait_to(266);
        check("t3_frames", cap[31:0], {16'h0333, 16'h4444});
        wait_to(269);
        check("t3_busy_T269", busy0, 0);
        check("t3_overrun_held", overrun0, 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("t3_overrun_clr", overrun0, 0);
        repeat (3) tick();

        // Overwrite and clear in the same cycle: set wins
        start(1'b0, 11'h0AA, 11'h055);
        wait_to(20);
        strobe0(11'h111, 11'h222, 1'b0);
        wait_to(40);
        strobe0(11'h333, 11'h444, 1'b1);
        check("t4_set_wins", overrun0, 1);

        // Reset mid-frame of the following request
        wait_to(60);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_cs_n", cs_n0, 1);
        check("t5_sclk", sclk0, 0);
        check("t5_busy", busy0, 0);
        check("t5_io_update", io_update0, 0);
        check("t5_overrun", overrun0, 0);
        check("t5_state", state_dbg0, 0);
        act = 0;
        repeat (200) tick();
        check("t5_no_activity", act, 0);

        // CLK_DIV = 1, UPDATE_W = 1
        start(1'b1, 11'h5A3, 11'h123);
        check("t6_cs_n_T1", cs_n1, 0);
        check("t6_sclk_T1", sclk1, 0);
        wait_to(2);
        check("t6_sclk_T2", sclk1, 1);
        wait_to(32);
        check("t6_cs_n_T32", cs_n1, 0);
        wait_to(33);
        check("t6_cs_n_T33", cs_n1, 1);
        check("t6_frame_a", cap[15:0], 16'h05A3);
        wait_to(66);
        check("t6_io_update_T66", io_update1, 0);
        check("t6_frames", cap[31:0], {16'h05A3, 16'h4123});
        wait_to(67);
        check("t6_io_update_T67", io_update1, 1);
        wait_to(68);
        check("t6_io_update_T68", io_update1, 0);
        check("t6_busy_T68", busy1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
